instr_prefetch_queue: RTL and testbench

//  Prefetch stage between instruction memory and decode/main control of KGP-RISC.

---
 rtl/kgp_risc_pkg.sv | 21 ++
 rtl/pfq_ring_buffer.sv | 62 ++++++
 rtl/instr_prefetch_queue.sv | 149 ++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC constants and the prefetch queue entry type.
// Used by instr_prefetch_queue and pfq_ring_buffer.
package kgp_risc_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } pfq_entry_t;

  // Saturating increment for the performance counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pfq_ring_buffer.sv
// DEPTH-entry ring buffer of {pc, instr} entries with wrap-bit pointers.
// Flush empties the buffer; writes in a flush cycle are ignored.
module pfq_ring_buffer
  import kgp_risc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  pfq_entry_t    push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [PtrW:0] count_o,
  output pfq_entry_t    head_o
);

  localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

  logic [PtrW:0] head_q, head_d;
  logic [PtrW:0] tail_q, tail_d;
  pfq_entry_t    mem_q [DEPTH];
  pfq_entry_t    mem_d [DEPTH];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    mem_d  = mem_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (push_i) begin
        mem_d[tail_q[PtrW-1:0]] = push_data_i;
        tail_d                  = tail_q + PtrOne;
      end
      if (pop_i) begin
        head_d = head_q + PtrOne;
      end
    end
  end

  assign count_o = tail_q - head_q;
  assign head_o  = mem_q[head_q[PtrW-1:0]];

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: credit-based sequential fetch, in-order buffering, redirect flush.
// Define PFQ_PERF_CNT_EN to add the saturating perf_flush_cnt / perf_stall_cnt outputs.
module instr_prefetch_queue
  import kgp_risc_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
`ifdef PFQ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_flush_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int unsigned       CntW   = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0]   CntOne = {{(CntW-1){1'b0}}, 1'b1};
  localparam logic [CntW:0]     DepthC = (CntW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] Step   = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   drop_q, drop_d;
  logic [CntW-1:0]   count;
  logic [CntW:0]     credit_used;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              push;
  logic              pop;
  pfq_entry_t        push_entry;
  pfq_entry_t        head_entry;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign redirect_tgt  = {redirect_pc[ADDR_W-1:2], 2'b00};

  // In-flight requests include those already marked for dropping, so credits bound total traffic.
  assign credit_used = {1'b0, count} + {1'b0, outstanding_q};
  assign imem_req    = rst && !redirect && (credit_used < DepthC);
  assign imem_addr   = fetch_pc_q;

  assign instr_valid = (count != '0);
  assign instr       = head_entry.instr;
  assign instr_pc    = ADDR_W'(head_entry.pc);
  assign pop         = instr_valid && instr_ready;
  assign push        = imem_rvalid && !redirect && (drop_q == '0);

  assign push_entry.pc    = XLEN'(rsp_pc_q);
  assign push_entry.instr = imem_rdata;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    unique case ({imem_req, imem_rvalid})
      2'b10:   outstanding_d = outstanding_q + CntOne;
      2'b01:   outstanding_d = outstanding_q - CntOne;
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      drop_d     = outstanding_d;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + Step;
      end
      if (imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - CntOne;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + Step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  pfq_ring_buffer #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect),
    .count_o     (count),
    .head_o      (head_entry)
  );

`ifdef PFQ_PERF_CNT_EN
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    flush_cnt_d = redirect ? sat_inc32(flush_cnt_q) : flush_cnt_q;
    stall_cnt_d = (instr_ready && !instr_valid) ? sat_inc32(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_flush_cnt = flush_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // A response with nothing in flight means the memory side broke the protocol.
  rsp_legal_a: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (outstanding_q != '0));
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with an in-order memory model returning addr as data.
// Covers streaming, backpressure, redirects with in-flight drops, address wrap and async reset.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef PFQ_PERF_CNT_EN
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .DEPTH    (4),
    .ADDR_W   (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef PFQ_PERF_CNT_EN
    ,
    .perf_flush_cnt (perf_flush_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    bit          do_rst;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          cyc = 0;
  logic        mv [16];
  logic [31:0] ma [16];
  vec_t        tbl[$];

  function automatic vec_t mk(bit do_rst, bit redir, logic [31:0] rpc, bit rdy, bit e_req,
                              logic [31:0] e_addr, bit e_valid, logic [31:0] e_pc);
    vec_t v;
    v.do_rst = do_rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      ma[i] = '0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  // One cycle: drive inputs and memory response, check outputs mid-cycle, then advance.
  task automatic step(input string tag, input bit redir, input logic [31:0] rpc, input bit rdy,
                      input bit e_req, input logic [31:0] e_addr, input bit e_valid,
                      input logic [31:0] e_pc);
    int idx;
    idx         = cyc % 16;
    redirect    = redir;
    redirect_pc = rpc;
    instr_ready = rdy;
    imem_rvalid = mv[idx];
    imem_rdata  = ma[idx];
    mv[idx]     = 1'b0;
    #2;
    chk($sformatf("%s/c%0d imem_req", tag, cyc), 32'(imem_req), 32'(e_req));
    if (e_req) chk($sformatf("%s/c%0d imem_addr", tag, cyc), imem_addr, e_addr);
    chk($sformatf("%s/c%0d instr_valid", tag, cyc), 32'(instr_valid), 32'(e_valid));
    if (e_valid) begin
      chk($sformatf("%s/c%0d instr_pc", tag, cyc), instr_pc, e_pc);
      chk($sformatf("%s/c%0d instr", tag, cyc), instr, e_pc);
    end
    if (imem_req) begin
      mv[(cyc + lat) % 16] = 1'b1;
      ma[(cyc + lat) % 16] = imem_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect = 1'b0;
  endtask

  initial begin
    // Streaming from reset, L=1, ready=1: no bubbles once the first word lands.
    for (int c = 0; c < 8; c++) begin
      tbl.push_back(mk(c == 0, 0, 0, 1, 1, 32'(4 * c), c >= 2, 32'(4 * (c - 2))));
    end
    // Backpressure: four requests fill the queue, then drain in order.
    tbl.push_back(mk(1, 0, 0, 0, 1, 32'd0,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'd4,  0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'd8,  1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'd12, 1, 0));
    for (int c = 4; c < 10; c++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'd0,  1, 32'd0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'd16, 1, 32'd4));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'd20, 1, 32'd8));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'd24, 1, 32'd12));
    tbl.push_back(mk(0, 0, 0, 1, 1, 32'd28, 1, 32'd16));

    rst = 1'b0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    #12;
    chk("reset imem_req", 32'(imem_req), 32'd0);
    chk("reset instr_valid", 32'(instr_valid), 32'd0);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset instr", instr, 32'h0);
    chk("reset instr_pc", instr_pc, 32'h0);

    lat = 1;
    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      step($sformatf("tbl%0d", i), tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].e_req,
           tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc);
    end

    // L=3, redirect to 0x100 with two requests in flight: both stale words dropped.
    lat = 3;
    do_reset();
    step("l3", 0, 0,          1, 1, 32'h0,   0, 0);
    step("l3", 0, 0,          1, 1, 32'h4,   0, 0);
    step("l3", 1, 32'h100,    1, 0, 32'h0,   0, 0);
    step("l3", 0, 0,          1, 1, 32'h100, 0, 0);
    step("l3", 0, 0,          1, 1, 32'h104, 0, 0);
    step("l3", 0, 0,          1, 1, 32'h108, 0, 0);
    step("l3", 0, 0,          1, 1, 32'h10c, 0, 0);
    step("l3", 0, 0,          1, 0, 32'h0,   1, 32'h100);
    step("l3", 0, 0,          1, 1, 32'h110, 1, 32'h104);
    step("l3", 0, 0,          1, 1, 32'h114, 1, 32'h108);

    // Redirect coinciding with a pop and an arriving response.
    lat = 1;
    do_reset();
    step("rpop", 0, 0,       1, 1, 32'h0,   0, 0);
    step("rpop", 0, 0,       1, 1, 32'h4,   0, 0);
    step("rpop", 0, 0,       1, 1, 32'h8,   1, 32'h0);
    step("rpop", 1, 32'h200, 1, 0, 32'h0,   1, 32'h4);
    step("rpop", 0, 0,       1, 1, 32'h200, 0, 0);
    step("rpop", 0, 0,       1, 1, 32'h204, 0, 0);
    step("rpop", 0, 0,       1, 1, 32'h208, 1, 32'h200);
    step("rpop", 0, 0,       1, 1, 32'h20c, 1, 32'h204);

    // Address wrap at the top of memory, then an unaligned target.
    do_reset();
    step("wrap", 0, 0,            1, 1, 32'h0,         0, 0);
    step("wrap", 1, 32'hFFFFFFFC, 1, 0, 32'h0,         0, 0);
    step("wrap", 0, 0,            1, 1, 32'hFFFFFFFC,  0, 0);
    step("wrap", 0, 0,            1, 1, 32'h0,         0, 0);
    step("wrap", 0, 0,            1, 1, 32'h4,         1, 32'hFFFFFFFC);
    step("wrap", 0, 0,            1, 1, 32'h8,         1, 32'h0);
    step("wrap", 1, 32'h103,      1, 0, 32'h0,         1, 32'h4);
    step("wrap", 0, 0,            1, 1, 32'h100,       0, 0);
    step("wrap", 0, 0,            1, 1, 32'h104,       0, 0);
    step("wrap", 0, 0,            1, 1, 32'h108,       1, 32'h100);
`ifdef PFQ_PERF_CNT_EN
    chk("perf_flush_cnt", perf_flush_cnt, 32'd2);
    chk("perf_stall_cnt", perf_stall_cnt, 32'd6);
`endif

    // Asynchronous reset with a full queue, then restart from RESET_PC.
    do_reset();
    step("arst", 0, 0, 0, 1, 32'h0,  0, 0);
    step("arst", 0, 0, 0, 1, 32'h4,  0, 0);
    step("arst", 0, 0, 0, 1, 32'h8,  1, 0);
    step("arst", 0, 0, 0, 1, 32'hc,  1, 0);
    step("arst", 0, 0, 0, 0, 32'h0,  1, 0);
    step("arst", 0, 0, 0, 0, 32'h0,  1, 0);
    chk("arst pre imem_addr", imem_addr, 32'h10);
    #2;
    rst = 1'b0;
    #1;
    chk("arst imem_req", 32'(imem_req), 32'd0);
    chk("arst instr_valid", 32'(instr_valid), 32'd0);
    chk("arst imem_addr", imem_addr, 32'h0);
    chk("arst instr", instr, 32'h0);
    chk("arst instr_pc", instr_pc, 32'h0);
`ifdef PFQ_PERF_CNT_EN
    chk("arst perf_flush_cnt", perf_flush_cnt, 32'd0);
    chk("arst perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif
    do_reset();
    step("arst2", 0, 0, 1, 1, 32'h0, 0, 0);
    step("arst2", 0, 0, 1, 1, 32'h4, 0, 0);
    step("arst2", 0, 0, 1, 1, 32'h8, 1, 32'h0);
    step("arst2", 0, 0, 1, 1, 32'hc, 1, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
